rng_share_ctrl: RTL and testbench

- Controller that owns a 16-bit Galois LFSR and shares its output among NUM_REQ requesters.
- Sequences seeding and warm-up, then hands out one random word per grant.
- Requesters are served by round-robin arbitration.
- Sits between the random-number datapath and the consumer blocks that need random values (stimulus engines, backoff timers).

---
 rtl/rng_share_ctrl_pkg.sv | 18 +
 rtl/rng_share_ctrl_rr_arbiter.sv | 46 ++++
 rtl/rng_share_ctrl.sv | 141 ++++++++++++++
 tb/tb_rng_share_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rng_share_ctrl_pkg.sv
// Shared types and the LFSR step used by the random-number sharing controller.
package rng_share_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    WARM  = 2'd1,
    SERVE = 2'd2
  } state_e;

  // Right-shifting Galois form; taps folded in when the bit shifted out is 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? LFSR_POLY : {LFSR_W{1'b0}});
  endfunction

endpackage

// File: rtl/rng_share_ctrl_rr_arbiter.sv
// Round-robin one-hot picker; search starts at the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       take,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx,
  output logic                       pick_any
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] ptr;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ))
        sum = sum - (IDW+1)'(NUM_REQ);
      cand = sum[IDW-1:0];
      if (!pick_any && req[cand]) begin
        pick_any   = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      ptr <= '0;
    else if (take && pick_any)
      ptr <= (pick_idx == IDW'(NUM_REQ-1)) ? '0 : pick_idx + IDW'(1);
  end

endmodule

// File: rtl/rng_share_ctrl.sv
// Shares one 16-bit Galois LFSR among NUM_REQ requesters with seeding, warm-up and RR grants.
// Optional per-requester saturating grant counters: define RNG_SHARE_GRANT_CNT_EN.
module rng_share_ctrl
  import rng_share_pkg::*;
#(
  parameter int                NUM_REQ      = 4,
  parameter int                WARMUP       = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seed_valid,
  input  logic [LFSR_W-1:0]          seed,
  output logic                       busy,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rnd_valid,
  output logic [LFSR_W-1:0]          rnd_data,
`ifdef RNG_SHARE_GRANT_CNT_EN
  output logic [NUM_REQ*16-1:0]      grant_cnt,
`endif
  output logic [$clog2(NUM_REQ)-1:0] rnd_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_e            state;
  logic [LFSR_W-1:0] lfsr;
  logic [WCW-1:0]    warm_cnt;
  logic              busy_q;

  logic [NUM_REQ-1:0] gnt_p1;
  logic [LFSR_W-1:0]  rnd_data_p1;
  logic [IDW-1:0]     rnd_id_p1;

  logic [NUM_REQ-1:0] pick;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               take;

  // A zero seed would lock the LFSR at zero forever.
  function automatic logic [LFSR_W-1:0] seed_sel(input logic [LFSR_W-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

  // A seed load in the same cycle wins over any grant.
  assign take = (state == SERVE) && !seed_valid && pick_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .take     (take),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // Stage p1: FSM, LFSR and registered grant outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= INIT;
      lfsr        <= DEFAULT_SEED;
      warm_cnt    <= '0;
      busy_q      <= 1'b1;
      gnt_p1      <= '0;
      rnd_data_p1 <= '0;
      rnd_id_p1   <= '0;
    end else begin
      gnt_p1 <= '0;
      if (seed_valid) begin
        lfsr     <= seed_sel(seed);
        warm_cnt <= '0;
        state    <= WARM;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          INIT: begin
            state    <= WARM;
            warm_cnt <= '0;
            busy_q   <= 1'b1;
          end
          WARM: begin
            lfsr <= lfsr_step(lfsr);
            if (warm_cnt == WCW'(WARMUP-1)) begin
              state  <= SERVE;
              busy_q <= 1'b0;
            end else begin
              warm_cnt <= warm_cnt + WCW'(1);
            end
          end
          SERVE: begin
            // Stepping only on grants keeps the word sequence independent of idle time.
            if (take) begin
              gnt_p1      <= pick;
              rnd_data_p1 <= lfsr;
              rnd_id_p1   <= pick_idx;
              lfsr        <= lfsr_step(lfsr);
            end
          end
          default: begin
            state  <= INIT;
            busy_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign gnt       = gnt_p1;
  assign rnd_valid = |gnt_p1;
  assign rnd_data  = rnd_data_p1;
  assign rnd_id    = rnd_id_p1;

`ifdef RNG_SHARE_GRANT_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_q [NUM_REQ];

  // Counters advance on the same edge that registers the grant they count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!reset || seed_valid)
        cnt_q[i] <= '0;
      else if (take && pick[i])
        cnt_q[i] <= sat_inc(cnt_q[i]);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench for rng_share_ctrl (NUM_REQ=4, WARMUP=1); one task per scenario.
module tb_rng_share_ctrl;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          seed_valid;
  logic [15:0]   seed;
  logic          busy;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic          rnd_valid;
  logic [15:0]   rnd_data;
  logic [1:0]    rnd_id;
`ifdef RNG_SHARE_GRANT_CNT_EN
  logic [NR*16-1:0] grant_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rng_share_ctrl #(
    .NUM_REQ      (NR),
    .WARMUP       (1),
    .DEFAULT_SEED (16'hACE1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed       (seed),
    .busy       (busy),
    .req        (req),
    .gnt        (gnt),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
`ifdef RNG_SHARE_GRANT_CNT_EN
    .grant_cnt  (grant_cnt),
`endif
    .rnd_id     (rnd_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic test_reset();
    reset = 1'b0; seed_valid = 1'b0; seed = 16'h0000; req = '0;
    tick(); tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); end
    n_vec++; if (rnd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rnd_valid); end
    n_vec++; if (rnd_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", rnd_data); end
    n_vec++; if (rnd_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", rnd_id); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
`ifdef RNG_SHARE_GRANT_CNT_EN
    n_vec++; if (grant_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", grant_cnt); end
`endif
  endtask

  task automatic test_basic();
    reset = 1'b1; req = 4'b0001;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_init: got %b want 1", busy); end
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_warm: got %b want 1", busy); end
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL basic_gnt_warm: got %b want 0000", gnt); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_serve: got %b want 0", busy); end
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL basic_gnt_entry: got %b want 0000", gnt); end
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL basic_gnt1: got %b want 0001", gnt); end
    n_vec++; if (rnd_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid1: got %b want 1", rnd_valid); end
    n_vec++; if (rnd_data !== 16'hE270) begin n_err++; $display("FAIL basic_data1: got %h want e270", rnd_data); end
    n_vec++; if (rnd_id !== 2'd0) begin n_err++; $display("FAIL basic_id1: got %0d want 0", rnd_id); end
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL basic_gnt2: got %b want 0001", gnt); end
    n_vec++; if (rnd_data !== 16'h7138) begin n_err++; $display("FAIL basic_data2: got %h want 7138", rnd_data); end
    req = 4'b0000;
    tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL basic_idle_gnt: got %b want 0000", gnt); end
    n_vec++; if (rnd_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid: got %b want 0", rnd_valid); end
    n_vec++; if (rnd_data !== 16'h7138) begin n_err++; $display("FAIL basic_idle_hold: got %h want 7138", rnd_data); end
  endtask

  task automatic test_seed_one();
    seed_valid = 1'b1; seed = 16'h0001;
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL seed1_busy: got %b want 1", busy); end
    seed_valid = 1'b0; req = 4'b0010;
    tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL seed1_gnt_warm: got %b want 0000", gnt); end
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL seed1_gnt: got %b want 0010", gnt); end
    n_vec++; if (rnd_id !== 2'd1) begin n_err++; $display("FAIL seed1_id: got %0d want 1", rnd_id); end
    n_vec++; if (rnd_data !== 16'hB400) begin n_err++; $display("FAIL seed1_data: got %h want b400", rnd_data); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_zero_seed();
    seed_valid = 1'b1; seed = 16'h0000;
    tick();
    seed_valid = 1'b0; req = 4'b0001;
    tick();
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL zseed_gnt: got %b want 0001", gnt); end
    n_vec++; if (rnd_data !== 16'hE270) begin n_err++; $display("FAIL zseed_data1: got %h want e270", rnd_data); end
    tick();
    n_vec++; if (rnd_data !== 16'h7138) begin n_err++; $display("FAIL zseed_data2: got %h want 7138", rnd_data); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0]   m_lfsr;
    logic [NR-1:0] exp_gnt;
    reset = 1'b0;
    tick();
    reset = 1'b1; req = 4'b1111;
    tick();
    tick();
    m_lfsr = 16'hE270;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_gnt = 4'b0001 << (k % 4);
      n_vec++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); end
      n_vec++; if (rnd_id !== 2'(k % 4)) begin n_err++; $display("FAIL b2b_id[%0d]: got %0d want %0d", k, rnd_id, k % 4); end
      n_vec++; if (rnd_data !== m_lfsr) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rnd_data, m_lfsr); end
      m_lfsr = ref_step(m_lfsr);
    end
`ifdef RNG_SHARE_GRANT_CNT_EN
    n_vec++; if (grant_cnt !== {4{16'd2}}) begin n_err++; $display("FAIL b2b_cnt: got %h want %h", grant_cnt, {4{16'd2}}); end
`endif
  endtask

  task automatic test_seed_pending();
    seed_valid = 1'b1; seed = 16'h0001;
    tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL seedp_gnt: got %b want 0000", gnt); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL seedp_busy: got %b want 1", busy); end
`ifdef RNG_SHARE_GRANT_CNT_EN
    n_vec++; if (grant_cnt !== '0) begin n_err++; $display("FAIL seedp_cnt_clr: got %h want 0", grant_cnt); end
`endif
    seed_valid = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL seedp_busy_end: got %b want 0", busy); end
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL seedp_gnt_warm: got %b want 0000", gnt); end
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL seedp_gnt0: got %b want 0001", gnt); end
    n_vec++; if (rnd_data !== 16'hB400) begin n_err++; $display("FAIL seedp_data0: got %h want b400", rnd_data); end
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL seedp_gnt1: got %b want 0010", gnt); end
    n_vec++; if (rnd_data !== 16'h5A00) begin n_err++; $display("FAIL seedp_data1: got %h want 5a00", rnd_data); end
`ifdef RNG_SHARE_GRANT_CNT_EN
    n_vec++; if (grant_cnt[15:0] !== 16'd1) begin n_err++; $display("FAIL seedp_cnt0: got %0d want 1", grant_cnt[15:0]); end
`endif
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rmid_gnt: got %b want 0000", gnt); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy: got %b want 1", busy); end
    n_vec++; if (rnd_data !== 16'h0000) begin n_err++; $display("FAIL rmid_data: got %h want 0000", rnd_data); end
    n_vec++; if (rnd_id !== 2'd0) begin n_err++; $display("FAIL rmid_id: got %0d want 0", rnd_id); end
`ifdef RNG_SHARE_GRANT_CNT_EN
    n_vec++; if (grant_cnt !== '0) begin n_err++; $display("FAIL rmid_cnt: got %h want 0", grant_cnt); end
`endif
    reset = 1'b1;
    tick();
    tick();
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rmid_gnt0: got %b want 0001", gnt); end
    n_vec++; if (rnd_data !== 16'hE270) begin n_err++; $display("FAIL rmid_data0: got %h want e270", rnd_data); end
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL rmid_gnt1: got %b want 0010", gnt); end
    n_vec++; if (rnd_data !== 16'h7138) begin n_err++; $display("FAIL rmid_data1: got %h want 7138", rnd_data); end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed_one();
    test_zero_seed();
    test_back_to_back();
    test_seed_pending();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
